// File: rtl/vc_flow_pkg.sv
// Shared constants for the virtual-channel flow controller: FSM state encoding
// and default FIFO geometry.
// Latency: n/a (constants only). Backpressure: n/a.
package vc_flow_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

  localparam int DEPTH_DEF      = 8;
  localparam int CNT_W_DEF      = 4;
  localparam int THR_AF_DEF_DEF = 6;

endpackage

// File: rtl/vc_rr_arbiter.sv
// Two-requester round-robin arbiter that remembers the last requester it served.
// Latency: gnt is combinational from req; the history register updates on the grant edge.
// Backpressure: a requester that is not granted simply keeps requesting; gnt is one-hot or 0.
// Ports: clk, reset (sync, active-high), req[1:0] (bit0=VC0, bit1=VC1), gnt[1:0].
module vc_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 0 = VC0 was served last, 1 = VC1 was served last.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Contention: serve whichever side did not win last time.
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[0]) begin
      last_grant_d = 1'b0;
    end else if (gnt[1]) begin
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/vc_flow_controller.sv
// Gates main-FIFO pops into the VC0/VC1 demux and round-robins VC0/VC1 onto the D0/D1 port.
// Latency: pops are combinational from registered state + same-cycle counts; state/flags registered.
// Backpressure: a pop is withheld while its destination FIFO count is at or above thr_af_q.
// Ports: clk/reset/init/thr_af_in control; *_count FIFO occupancies; head-word routing bits;
//        push_* observed pushes for overflow detection; pop_* grants; state and status flags.
module vc_flow_controller
  import vc_flow_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int THR_AF_DEF = THR_AF_DEF_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [CNT_W-1:0]   thr_af_in,
  input  logic [CNT_W-1:0]   main_count,
  input  logic [CNT_W-1:0]   vc0_count,
  input  logic [CNT_W-1:0]   vc1_count,
  input  logic [CNT_W-1:0]   d0_count,
  input  logic [CNT_W-1:0]   d1_count,
  input  logic               main_head_vc,
  input  logic               vc0_head_dest,
  input  logic               vc1_head_dest,
  input  logic               push_vc0,
  input  logic               push_vc1,
  input  logic               push_d0,
  input  logic               push_d1,
  output logic               pop_main,
  output logic               pop_vc0,
  output logic               pop_vc1,
  output logic [STATE_W-1:0] state,
  output logic               idle_out,
  output logic               active_out,
  output logic               error_out
);

  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  // Two words can be in flight through the registered demux before a count
  // reflects a pop, so the threshold never exceeds DEPTH-2.
  localparam logic [CNT_W-1:0] THR_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] THR_RST = CNT_W'(THR_AF_DEF);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   thr_af_q, thr_af_d;
  logic               idle_q, active_q, error_q;

  logic               err_cond;
  logic               all_empty;
  logic               run;
  logic [CNT_W-1:0]   main_dest_cnt;
  logic [CNT_W-1:0]   vc0_dest_cnt;
  logic [CNT_W-1:0]   vc1_dest_cnt;
  logic [1:0]         req;
  logic [1:0]         gnt;

  assign err_cond = (push_vc0 && (vc0_count == FULL)) ||
                    (push_vc1 && (vc1_count == FULL)) ||
                    (push_d0  && (d0_count  == FULL)) ||
                    (push_d1  && (d1_count  == FULL));

  assign all_empty = (main_count == '0) && (vc0_count == '0) && (vc1_count == '0) &&
                     (d0_count == '0) && (d1_count == '0);

  // Threshold is re-sampled on every INIT cycle, so the value seen on the
  // last INIT cycle is the one that applies once the run states resume.
  always_comb begin
    thr_af_d = thr_af_q;
    if (state_q == ST_INIT) begin
      thr_af_d = (thr_af_in > THR_MAX) ? THR_MAX : thr_af_in;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = ST_RESET;
    end else begin
      unique case (state_q)
        ST_RESET: state_d = ST_INIT;
        ST_INIT:  state_d = init ? ST_INIT : ST_IDLE;
        ST_IDLE, ST_ACTIVE: begin
          if (err_cond) begin
            state_d = ST_ERROR;
          end else if (init) begin
            state_d = ST_INIT;
          end else if (all_empty) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ERROR;
      endcase
    end
  end

  // State register; status flags decode the next state so they move with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      thr_af_q <= THR_RST;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      thr_af_q <= thr_af_d;
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

  // Output logic: pops are only ever issued from the run states.
  always_comb begin
    run           = !reset && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
    main_dest_cnt = main_head_vc  ? vc1_count : vc0_count;
    vc0_dest_cnt  = vc0_head_dest ? d1_count  : d0_count;
    vc1_dest_cnt  = vc1_head_dest ? d1_count  : d0_count;
    pop_main      = run && (main_count != '0) && (main_dest_cnt < thr_af_q);
    req[0]        = run && (vc0_count != '0) && (vc0_dest_cnt < thr_af_q);
    req[1]        = run && (vc1_count != '0) && (vc1_dest_cnt < thr_af_q);
  end

  vc_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign pop_vc0    = gnt[0];
  assign pop_vc1    = gnt[1];
  assign state      = state_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign error_out  = error_q;

endmodule

// File: tb/tb_vc_flow_controller.sv
// Self-checking bench for vc_flow_controller: directed scenarios followed by random traffic,
// all checked against a behavioural model of the flow-control rules.
// Latency/backpressure expectations come from the model, evaluated once per clock.
module tb_vc_flow_controller;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] thr_af_in;
  logic [3:0] main_count, vc0_count, vc1_count, d0_count, d1_count;
  logic       main_head_vc, vc0_head_dest, vc1_head_dest;
  logic       push_vc0, push_vc1, push_d0, push_d1;
  logic       pop_main, pop_vc0, pop_vc1;
  logic [2:0] state;
  logic       idle_out, active_out, error_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: FSM state number, effective threshold, side served last.
  int m_state = 0;
  int m_thr   = 6;
  int m_last  = 1;
  logic x_main, x_vc0, x_vc1;

  always #5 clk = ~clk;

  vc_flow_controller dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .thr_af_in     (thr_af_in),
    .main_count    (main_count),
    .vc0_count     (vc0_count),
    .vc1_count     (vc1_count),
    .d0_count      (d0_count),
    .d1_count      (d1_count),
    .main_head_vc  (main_head_vc),
    .vc0_head_dest (vc0_head_dest),
    .vc1_head_dest (vc1_head_dest),
    .push_vc0      (push_vc0),
    .push_vc1      (push_vc1),
    .push_d0       (push_d0),
    .push_d1       (push_d1),
    .pop_main      (pop_main),
    .pop_vc0       (pop_vc0),
    .pop_vc1       (pop_vc1),
    .state         (state),
    .idle_out      (idle_out),
    .active_out    (active_out),
    .error_out     (error_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected pops from the rules: a pop needs data and room below the threshold
  // at its destination; on contention the side not served last wins.
  function automatic void model_pops();
    bit run;
    int dm, d0v, d1v;
    bit e0, e1;
    run = !reset && (m_state == 2 || m_state == 3);
    dm  = main_head_vc  ? int'(vc1_count) : int'(vc0_count);
    d0v = vc0_head_dest ? int'(d1_count)  : int'(d0_count);
    d1v = vc1_head_dest ? int'(d1_count)  : int'(d0_count);
    x_main = run && main_count != 0 && dm < m_thr;
    e0 = run && vc0_count != 0 && d0v < m_thr;
    e1 = run && vc1_count != 0 && d1v < m_thr;
    x_vc0 = e0 && (!e1 || m_last == 1);
    x_vc1 = e1 && !x_vc0;
  endfunction

  function automatic void model_advance();
    bit ovf, empty;
    ovf = (push_vc0 && vc0_count == 8) || (push_vc1 && vc1_count == 8) ||
          (push_d0 && d0_count == 8) || (push_d1 && d1_count == 8);
    empty = (main_count + vc0_count + vc1_count + d0_count + d1_count) == 0;
    if (reset) begin
      m_state = 0;
      m_thr   = 6;
      m_last  = 1;
    end else begin
      if (x_vc0) m_last = 0;
      else if (x_vc1) m_last = 1;
      case (m_state)
        0: m_state = 1;
        1: begin
          m_thr = (thr_af_in > 6) ? 6 : int'(thr_af_in);
          if (!init) m_state = 2;
        end
        2, 3: begin
          if (ovf) m_state = 4;
          else if (init) m_state = 1;
          else if (empty) m_state = 2;
          else m_state = 3;
        end
        default: m_state = 4;
      endcase
    end
  endfunction

  // One clock: check pops mid-cycle, advance model, check registered outputs after the edge.
  task automatic tick();
    @(negedge clk);
    model_pops();
    chk("pop_main", pop_main, x_main);
    chk("pop_vc0", pop_vc0, x_vc0);
    chk("pop_vc1", pop_vc1, x_vc1);
    chk("pop_exclusive", pop_vc0 && pop_vc1, 0);
    model_advance();
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("idle_out", idle_out, m_state == 2);
    chk("active_out", active_out, m_state == 3);
    chk("error_out", error_out, m_state == 4);
  endtask

  task automatic zero_counts();
    main_count = 0; vc0_count = 0; vc1_count = 0; d0_count = 0; d1_count = 0;
  endtask

  initial begin
    int prev;
    int g;
    int err_cycles;
    reset = 1; init = 0; thr_af_in = 0;
    zero_counts();
    main_head_vc = 0; vc0_head_dest = 0; vc1_head_dest = 0;
    push_vc0 = 0; push_vc1 = 0; push_d0 = 0; push_d1 = 0;

    // Reset and init sequence.
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_error", error_out, 0);
    reset = 0; init = 1; thr_af_in = 5;
    tick();
    chk("init_state", state, 1);
    tick(); tick();
    init = 0;
    tick();
    chk("idle_state", state, 2);
    chk("idle_flag", idle_out, 1);

    // Threshold of 5 in effect.
    main_count = 1; vc0_count = 5; #1;
    chk("thr5_block", pop_main, 0);
    tick();
    vc0_count = 4; #1;
    chk("thr5_pass", pop_main, 1);
    tick();

    // Threshold clamp: 8 becomes 6.
    init = 1; thr_af_in = 8;
    tick();
    init = 0;
    tick();
    main_count = 3; vc0_count = 6; main_head_vc = 0; #1;
    chk("clamp_block", pop_main, 0);
    tick();
    vc0_count = 5; #1;
    chk("clamp_pass", pop_main, 1);
    tick();

    // Round-robin fairness.
    main_count = 0; vc0_count = 3; vc1_count = 3; d0_count = 0; d1_count = 0;
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_one_grant", pop_vc0 ^ pop_vc1, 1);
      g = pop_vc1 ? 1 : 0;
      if (prev >= 0) chk("rr_alternate", g, 1 - prev);
      prev = g;
      tick();
    end

    // Downstream backpressure on VC1's destination.
    vc1_head_dest = 1; d1_count = 6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_vc1_held", pop_vc1, 0);
      chk("bp_vc0_granted", pop_vc0, 1);
      tick();
    end

    // Re-init mid-traffic.
    vc1_head_dest = 0; d1_count = 0; thr_af_in = 6; #1;
    chk("reinit_pre", pop_vc0 | pop_vc1, 1);
    init = 1;
    tick();
    chk("reinit_state", state, 1);
    init = 0; #1;
    chk("reinit_pops_off", pop_vc0 | pop_vc1 | pop_main, 0);
    tick();
    #1;
    chk("reinit_resume", pop_vc0 | pop_vc1, 1);
    tick();
    chk("reinit_active", state, 3);

    // Overflow into full VC1 is sticky until reset.
    vc1_count = 8; push_vc1 = 1;
    tick();
    push_vc1 = 0;
    chk("ovf_state", state, 4);
    chk("ovf_flag", error_out, 1);
    #1;
    chk("ovf_pops_off", pop_vc0 | pop_vc1 | pop_main, 0);
    tick(); tick();
    chk("ovf_sticky", state, 4);
    reset = 1;
    tick();
    chk("ovf_reset", state, 0);
    reset = 0;

    // Random traffic against the model.
    err_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        zero_counts();
      end else begin
        main_count = 4'($urandom_range(0, 8));
        vc0_count  = 4'($urandom_range(0, 8));
        vc1_count  = 4'($urandom_range(0, 8));
        d0_count   = 4'($urandom_range(0, 8));
        d1_count   = 4'($urandom_range(0, 8));
      end
      main_head_vc  = 1'($urandom_range(0, 1));
      vc0_head_dest = 1'($urandom_range(0, 1));
      vc1_head_dest = 1'($urandom_range(0, 1));
      push_vc0 = ($urandom_range(0, 40) == 0);
      push_vc1 = ($urandom_range(0, 40) == 0);
      push_d0  = ($urandom_range(0, 40) == 0);
      push_d1  = ($urandom_range(0, 40) == 0);
      thr_af_in = 4'($urandom_range(0, 15));
      init = ($urandom_range(0, 30) == 0);
      err_cycles = (m_state == 4) ? err_cycles + 1 : 0;
      reset = ($urandom_range(0, 400) == 0) || (err_cycles > 8);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
